// File: rtl/subcarrier_pkg.sv
// Shared constants, types and helpers for the subcarrier phase controller.
// FSC_X4 values are 4*Fsc in Hz, rounded to the nearest integer.
package subcarrier_pkg;

   localparam int unsigned PHASE_W    = 40;
   localparam int unsigned SC_CLKHZ_W = 32;
   localparam int unsigned SC_DVD_W   = 64;
   localparam int unsigned SC_SHIFT   = 38;

   localparam logic [31:0] FSC_X4_NTSC = 32'd14_318_182;
   localparam logic [31:0] FSC_X4_PAL  = 32'd17_734_475;

   typedef enum logic [2:0] {
      ST_RESET,
      ST_LOAD,
      ST_DIV,
      ST_CHECK,
      ST_PEND,
      ST_IDLE
   } sc_state_t;

   typedef struct packed {
      logic [SC_CLKHZ_W-1:0] clk_hz;
      logic                  pal_en;
   } sc_cfg_t;

   function automatic logic [31:0] sc_fsc_x4(input logic pal_en);
      return pal_en ? FSC_X4_PAL : FSC_X4_NTSC;
   endfunction

   // FSC_X4 * 2^38 plus half the divisor, so the floor divide rounds
   function automatic logic [SC_DVD_W-1:0] sc_dividend(
      input logic                  pal_en,
      input logic [SC_CLKHZ_W-1:0] clk_hz
   );
      logic [SC_DVD_W-1:0] f;
      logic [SC_DVD_W-1:0] h;
      f = {32'd0, sc_fsc_x4(pal_en)};
      h = {32'd0, 1'b0, clk_hz[SC_CLKHZ_W-1:1]};
      return (f << SC_SHIFT) + h;
   endfunction

endpackage

// File: rtl/subcarrier_phase_ctrl_udiv.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// A start pulse (re)loads the operands; done pulses on the final step.
module udiv_seq #(
   parameter int unsigned DVD_W = 64,
   parameter int unsigned DVS_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_i,
   input  logic [DVD_W-1:0] dividend_i,
   input  logic [DVS_W-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [DVD_W-1:0] quotient_o
);

   localparam int unsigned CNT_W = $clog2(DVD_W);

   // dividend bits shift out the top while quotient bits shift in below
   logic [DVD_W-1:0] dq_q, dq_d;
   logic [DVS_W-1:0] rem_q, rem_d;
   logic [DVS_W-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d;
   logic [DVS_W:0]   rem_sh;
   logic [DVS_W:0]   rem_sub;
   logic             take;

   always_comb begin
      rem_sh  = {rem_q, dq_q[DVD_W-1]};
      rem_sub = rem_sh - {1'b0, dvs_q};
      take    = rem_sh >= {1'b0, dvs_q};
      dq_d    = dq_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      if (start_i) begin
         dq_d  = dividend_i;
         rem_d = '0;
         dvs_d = divisor_i;
         cnt_d = CNT_W'(DVD_W - 1);
         run_d = 1'b1;
      end else if (run_q) begin
         dq_d  = {dq_q[DVD_W-2:0], take};
         rem_d = take ? rem_sub[DVS_W-1:0]
                      : rem_sh[DVS_W-1:0];
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == '0) begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dq_q  <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         dq_q  <= dq_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign busy_o     = run_q;
   assign done_o     = run_q & ~start_i & (cnt_q == '0);
   assign quotient_o = dq_q;

endmodule

// File: rtl/subcarrier_phase_ctrl.sv
// Derives the subcarrier phase increment from clk_hz and the video
// standard, committing new values only at a vsync rise once running.
module subcarrier_phase_ctrl
   import subcarrier_pkg::*;
#(
   parameter int unsigned CLKHZ_W = 32,
   parameter int unsigned PHASE_W = subcarrier_pkg::PHASE_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [CLKHZ_W-1:0] clk_hz,
   input  logic               pal_en,
   input  logic               enable,
   input  logic               vsync,
   output logic [PHASE_W-1:0] phase_inc,
   output logic               phase_inc_valid,
   output logic               subcarrier_enable,
   output logic               busy,
   output logic               cfg_err
);

   sc_state_t state_q, state_d;
   sc_cfg_t   cfg_q, cfg_d, cfg_in;

   logic               vsync_d_q;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic               valid_q, valid_d;
   logic               err_q, err_d;
   logic               sen_q, sen_d;

   logic                cfg_chg;
   logic                vs_rise;
   logic                nyq_err;
   logic [31:0]         fsc;
   logic                div_start;
   logic                div_busy;
   logic                div_done;
   logic [SC_DVD_W-1:0] quot;
   logic                commit;
   logic                fail;

   assign cfg_in  = '{clk_hz: clk_hz, pal_en: pal_en};
   assign cfg_chg = cfg_in != cfg_q;
   assign vs_rise = vsync & ~vsync_d_q;
   assign fsc     = sc_fsc_x4(cfg_q.pal_en);

   // below Nyquist: clk_hz must be at least 2*Fsc (i.e. 2*clk >= 4*Fsc)
   assign nyq_err = (cfg_q.clk_hz == '0)
                  | ({cfg_q.clk_hz, 1'b0} < {1'b0, fsc});

   udiv_seq #(
      .DVD_W (SC_DVD_W),
      .DVS_W (CLKHZ_W)
   ) u_div (
      .clk        (clk),
      .reset_n    (reset_n),
      .start_i    (div_start),
      .dividend_i (sc_dividend(cfg_in.pal_en, cfg_in.clk_hz)),
      .divisor_i  (cfg_in.clk_hz),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quotient_o (quot)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RESET: state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_DIV;
         ST_DIV:   if (div_done) state_d = ST_CHECK;
         ST_CHECK: begin
            if (nyq_err || !valid_q) state_d = ST_IDLE;
            else                     state_d = ST_PEND;
         end
         ST_PEND:  if (vs_rise) state_d = ST_IDLE;
         ST_IDLE:  state_d = ST_IDLE;
         default:  state_d = ST_RESET;
      endcase
      // a new config aborts whatever is in flight
      if (cfg_chg && state_q != ST_LOAD && state_q != ST_RESET) begin
         state_d = ST_LOAD;
      end
   end

   always_comb begin
      div_start = 1'b0;
      commit    = 1'b0;
      fail      = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            div_start = 1'b1;
            busy      = 1'b1;
         end
         ST_DIV: busy = 1'b1;
         ST_CHECK: begin
            busy   = 1'b1;
            fail   = ~cfg_chg & nyq_err;
            commit = ~cfg_chg & ~nyq_err & ~valid_q;
         end
         ST_PEND: begin
            busy   = 1'b1;
            commit = ~cfg_chg & vs_rise;
         end
         default: busy = 1'b0;
      endcase
   end

   always_comb begin
      cfg_d   = cfg_q;
      phase_d = phase_q;
      valid_d = valid_q;
      err_d   = err_q;
      sen_d   = enable & valid_q;
      if (state_q == ST_LOAD) begin
         cfg_d = cfg_in;
      end
      if (commit) begin
         phase_d = quot[PHASE_W-1:0];
         valid_d = 1'b1;
         err_d   = 1'b0;
      end else if (fail) begin
         phase_d = '0;
         valid_d = 1'b0;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cfg_q     <= '0;
         vsync_d_q <= 1'b0;
         phase_q   <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         sen_q     <= 1'b0;
      end else begin
         cfg_q     <= cfg_d;
         vsync_d_q <= vsync;
         phase_q   <= phase_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         sen_q     <= sen_d;
      end
   end

   assign phase_inc         = phase_q;
   assign phase_inc_valid   = valid_q;
   assign subcarrier_enable = sen_q;
   assign cfg_err           = err_q;

endmodule

// File: tb/tb_subcarrier_phase_ctrl.sv
// Bench for subcarrier_phase_ctrl: directed scenarios plus random
// configuration/vsync/reset traffic against a behavioural model.
module tb_subcarrier_phase_ctrl;

   logic        clk;
   logic        reset_n;
   logic [31:0] clk_hz;
   logic        pal_en;
   logic        enable;
   logic        vsync;
   logic [39:0] phase_inc;
   logic        phase_inc_valid;
   logic        subcarrier_enable;
   logic        busy;
   logic        cfg_err;

   int n_chk = 0;
   int n_err = 0;

   subcarrier_phase_ctrl dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .clk_hz            (clk_hz),
      .pal_en            (pal_en),
      .enable            (enable),
      .vsync             (vsync),
      .phase_inc         (phase_inc),
      .phase_inc_valid   (phase_inc_valid),
      .subcarrier_enable (subcarrier_enable),
      .busy              (busy),
      .cfg_err           (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // rounded Fsc*2^40/clk_hz by plain 64-bit arithmetic
   function automatic logic [39:0] mq(input logic [31:0] hz,
                                      input logic pal);
      longint unsigned f, d, q;
      f = pal ? 64'd17734475 : 64'd14318182;
      if (hz == 0) return '0;
      d = (f << 38) + (longint'(hz) >> 1);
      q = d / longint'(hz);
      return q[39:0];
   endfunction

   function automatic bit m_bad(input logic [31:0] hz,
                                input logic pal);
      longint unsigned f;
      f = pal ? 64'd17734475 : 64'd14318182;
      return (hz == 0) || (2 * longint'(hz) < f);
   endfunction

   // model: m_k counts edges since the config was sampled
   // (1 = latch edge, 66 = evaluation edge, 99 = settled)
   bit          m_ready = 0;
   int          m_k = 0;
   logic [39:0] m_ph = '0;
   logic [39:0] m_pq = '0;
   bit          m_val = 0;
   bit          m_err = 0;
   bit          m_sen = 0;
   bit          m_vsd = 0;
   bit          m_pend = 0;
   logic [31:0] m_hz = '0;
   bit          m_pal = 0;

   always @(posedge clk) begin
      bit rise, chg;
      logic [39:0] q;
      if (!reset_n) begin
         m_ready = 1; m_k = 0; m_ph = '0; m_val = 0;
         m_err = 0; m_sen = 0; m_vsd = 0; m_pend = 0;
         m_hz = '0; m_pal = 0;
      end else begin
         rise  = vsync & ~m_vsd;
         m_vsd = vsync;
         m_sen = enable & m_val;
         chg   = (clk_hz != m_hz) || (pal_en != m_pal);
         if (m_k == 0) begin
            m_k = 1;
         end else if (m_k == 1) begin
            m_hz = clk_hz; m_pal = pal_en; m_k = 2;
         end else if (chg) begin
            m_k = 1; m_pend = 0;
         end else if (m_k < 66) begin
            m_k++;
         end else if (m_k == 66) begin
            m_k = 99;
            q = mq(m_hz, m_pal);
            if (m_bad(m_hz, m_pal)) begin
               m_err = 1; m_val = 0; m_ph = '0;
            end else if (!m_val) begin
               m_ph = q; m_val = 1; m_err = 0;
            end else begin
               m_pend = 1; m_pq = q;
            end
         end else if (m_pend && rise) begin
            m_ph = m_pq; m_val = 1; m_err = 0; m_pend = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ready) begin
         chk("phase_inc", 64'(phase_inc), 64'(m_ph));
         chk("valid", 64'(phase_inc_valid), 64'(m_val));
         chk("sc_enable", 64'(subcarrier_enable), 64'(m_sen));
         chk("busy", 64'(busy),
             64'(((m_k >= 1 && m_k <= 66) || m_pend) ? 1 : 0));
         chk("cfg_err", 64'(cfg_err), 64'(m_err));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [39:0] exp;
      int r;
      reset_n = 0; clk_hz = 32'd17_734_475; pal_en = 1;
      enable = 0; vsync = 0;
      step(3);
      chk("rst_phase", 64'(phase_inc), 0);
      chk("rst_valid", 64'(phase_inc_valid), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_err", 64'(cfg_err), 0);
      chk("rst_sen", 64'(subcarrier_enable), 0);

      // PAL at 4*Fsc: exactly 2^38, 66 cycles after release
      reset_n = 1;
      step(66);
      chk("lat65_valid", 64'(phase_inc_valid), 0);
      step(1);
      chk("lat66_valid", 64'(phase_inc_valid), 1);
      chk("pal_x4_phase", 64'(phase_inc), 64'h40_0000_0000);
      chk("pal_x4_model", 64'(m_ph), 64'h40_0000_0000);
      chk("pal_x4_err", 64'(cfg_err), 0);

      // NTSC at 4*Fsc, committed by vsync
      pal_en = 0; clk_hz = 32'd14_318_182;
      step(80);
      vsync = 1; step(3); vsync = 0; step(3);
      chk("ntsc_x4_phase", 64'(phase_inc), 64'h40_0000_0000);

      // double the clock: held until the vsync rise
      clk_hz = 32'd28_636_364;
      step(5);
      chk("x8_busy", 64'(busy), 1);
      step(100);
      chk("x8_hold", 64'(phase_inc), 64'h40_0000_0000);
      chk("x8_pend_busy", 64'(busy), 1);
      vsync = 1;
      step(1);
      chk("x8_commit", 64'(phase_inc), 64'h20_0000_0000);
      vsync = 0;
      step(3);

      // Nyquist boundary
      pal_en = 1; clk_hz = 32'd8_867_237;
      step(67);
      chk("nyq_err", 64'(cfg_err), 1);
      chk("nyq_phase", 64'(phase_inc), 0);
      chk("nyq_valid", 64'(phase_inc_valid), 0);
      clk_hz = 32'd8_867_238;
      step(66);
      chk("nyq_ok_early", 64'(cfg_err), 1);
      step(1);
      chk("nyq_ok_err", 64'(cfg_err), 0);
      chk("nyq_ok_valid", 64'(phase_inc_valid), 1);
      chk("nyq_ok_range",
          64'((phase_inc >= 40'h7F_FFFF_0000 &&
               phase_inc <= 40'h7F_FFFF_FFFF) ? 1 : 0), 1);
      chk("nyq_ok_phase", 64'(phase_inc),
          64'(mq(32'd8_867_238, 1'b1)));

      // standard toggled 30 steps into the divide
      clk_hz = 32'd1000;
      step(70);
      chk("low_err", 64'(cfg_err), 1);
      clk_hz = 32'd27_000_000;
      step(32);
      pal_en = 0;
      step(66);
      chk("abort_phase0", 64'(phase_inc), 0);
      chk("abort_valid0", 64'(phase_inc_valid), 0);
      step(1);
      chk("abort_valid", 64'(phase_inc_valid), 1);
      exp = mq(32'd27_000_000, 1'b0);
      chk("abort_phase", 64'(phase_inc), 64'(exp));

      // reset while pending, vsync toggling
      clk_hz = 32'd50_000_000; pal_en = 1;
      step(80);
      chk("pend_busy", 64'(busy), 1);
      reset_n = 0; vsync = 1;
      step(1);
      chk("rstp_phase", 64'(phase_inc), 0);
      chk("rstp_valid", 64'(phase_inc_valid), 0);
      chk("rstp_busy", 64'(busy), 0);
      reset_n = 1;
      for (int i = 0; i < 67; i++) begin
         vsync = ~vsync;
         step(1);
      end
      vsync = 0;
      chk("rstp_commit_v", 64'(phase_inc_valid), 1);
      chk("rstp_commit_p", 64'(phase_inc),
          64'(mq(32'd50_000_000, 1'b1)));

      // enable gating
      enable = 1;
      step(1);
      chk("en_on", 64'(subcarrier_enable), 1);
      enable = 0;
      step(1);
      chk("en_off", 64'(subcarrier_enable), 0);
      chk("en_phase", 64'(phase_inc),
          64'(mq(32'd50_000_000, 1'b1)));

      // config change on the vsync-rise cycle wins
      clk_hz = 32'd60_000_000;
      step(80);
      vsync = 1; clk_hz = 32'd70_000_000;
      step(1);
      chk("race_hold", 64'(phase_inc),
          64'(mq(32'd50_000_000, 1'b1)));
      chk("race_busy", 64'(busy), 1);
      vsync = 0;
      step(80);
      vsync = 1;
      step(1);
      chk("race_commit", 64'(phase_inc),
          64'(mq(32'd70_000_000, 1'b1)));
      vsync = 0;

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         enable = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 29) == 0) vsync = ~vsync;
         reset_n = $urandom_range(0, 1499) != 0;
         if ($urandom_range(0, 199) == 0) begin
            r = $urandom_range(0, 9);
            if (r == 0)      clk_hz = 0;
            else if (r < 3)  clk_hz = $urandom_range(1, 20_000_000);
            else if (r < 5)  pal_en = ~pal_en;
            else clk_hz = $urandom_range(8_000_000, 400_000_000);
         end
         step(1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
